// File: rtl/io_responder.sv
// Memory-mapped board I/O: HEX/LED output registers, synchronized switches and
// debounced keys with ready/overrun status, all with single-cycle read responses.
module io_responder #(
    parameter int DBITS           = 32,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [DBITS-1:0] req_addr,
    input  logic [DBITS-1:0] req_wdata,
    output logic             req_hit,
    output logic             rsp_valid,
    output logic [DBITS-1:0] rsp_rdata,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3,
    output logic [9:0]       LEDR,
    output logic [7:0]       LEDG
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [9:0] A_HEX     = 10'h000;
    localparam logic [9:0] A_LEDR    = 10'h001;
    localparam logic [9:0] A_LEDG    = 10'h002;
    localparam logic [9:0] A_KEYDATA = 10'h004;
    localparam logic [9:0] A_SWDATA  = 10'h005;
    localparam logic [9:0] A_KEYCTRL = 10'h044;

    logic [15:0]      hex_q, hex_d;
    logic [9:0]       ledr_q, ledr_d;
    logic [7:0]       ledg_q, ledg_d;
    logic [9:0]       sw_s1_q, sw_s2_q;
    logic [3:0]       key_s1_q, key_s2_q;
    logic [3:0]       key_deb_q, key_deb_d;
    logic [CW-1:0]    cnt_q [4];
    logic [CW-1:0]    cnt_d [4];
    logic             ready_q, ready_d;
    logic             overrun_q, overrun_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [DBITS-1:0] rsp_rdata_q, rsp_rdata_d;

    logic             acc;
    logic [9:0]       widx;
    logic [3:0]       key_sync;
    logic             key_change;
    logic             kd_read;
    logic [DBITS-1:0] rdata_mux;
    logic             unused_bits;

    assign unused_bits = ^{req_addr[1:0], req_wdata[DBITS-1:16]};

    assign req_hit  = (req_addr[31:12] == 20'hF0000);
    assign acc      = req_valid & req_hit;
    assign widx     = req_addr[11:2];
    assign key_sync = ~key_s2_q;
    assign kd_read  = acc & ~req_we & (widx == A_KEYDATA);

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Per-key debounce: count consecutive cycles the synchronized value disagrees.
    always_comb begin
        key_deb_d = key_deb_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (key_sync[i] != key_deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    key_deb_d[i] = key_sync[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign key_change = |(key_deb_d ^ key_deb_q);

    always_comb begin
        rdata_mux = '0;
        case (widx)
            A_HEX:     rdata_mux[15:0] = hex_q;
            A_LEDR:    rdata_mux[9:0]  = ledr_q;
            A_LEDG:    rdata_mux[7:0]  = ledg_q;
            A_KEYDATA: rdata_mux[3:0]  = key_deb_q;
            A_SWDATA:  rdata_mux[9:0]  = sw_s2_q;
            A_KEYCTRL: rdata_mux[2:0]  = {overrun_q, 1'b0, ready_q};
            default:   rdata_mux       = '0;
        endcase
    end

    always_comb begin
        hex_d       = hex_q;
        ledr_d      = ledr_q;
        ledg_d      = ledg_q;
        ready_d     = ready_q;
        overrun_d   = overrun_q;
        rsp_valid_d = acc & ~req_we;
        rsp_rdata_d = rsp_valid_d ? rdata_mux : '0;
        if (acc && req_we) begin
            case (widx)
                A_HEX:   hex_d  = req_wdata[15:0];
                A_LEDR:  ledr_d = req_wdata[9:0];
                A_LEDG:  ledg_d = req_wdata[7:0];
                default: ;
            endcase
        end
        // A fresh overrun beats a simultaneous clear; a fresh change beats a read.
        if (key_change && ready_q && !kd_read) begin
            overrun_d = 1'b1;
        end else if (acc && req_we && (widx == A_KEYCTRL) && !req_wdata[2]) begin
            overrun_d = 1'b0;
        end
        if (key_change) begin
            ready_d = 1'b1;
        end else if (kd_read) begin
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hex_q       <= '0;
            ledr_q      <= '0;
            ledg_q      <= '0;
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            key_s1_q    <= '0;
            key_s2_q    <= '0;
            key_deb_q   <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            ready_q     <= 1'b0;
            overrun_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            hex_q       <= hex_d;
            ledr_q      <= ledr_d;
            ledg_q      <= ledg_d;
            sw_s1_q     <= SW;
            sw_s2_q     <= sw_s1_q;
            key_s1_q    <= KEY;
            key_s2_q    <= key_s1_q;
            key_deb_q   <= key_deb_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            ready_q     <= ready_d;
            overrun_q   <= overrun_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign LEDR      = ledr_q;
    assign LEDG      = ledg_q;
    assign HEX0      = seg7(hex_q[3:0]);
    assign HEX1      = seg7(hex_q[7:4]);
    assign HEX2      = seg7(hex_q[11:8]);
    assign HEX3      = seg7(hex_q[15:12]);

endmodule

// File: tb/tb_io_responder.sv
// Bench for io_responder: directed scenarios plus random bus/key/switch traffic,
// all checked cycle by cycle against a behavioural model of the register map.
module tb_io_responder;

    localparam int DBITS = 32;
    localparam int DC    = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_we = 1'b0;
    logic [DBITS-1:0] req_addr = '0;
    logic [DBITS-1:0] req_wdata = '0;
    logic             req_hit;
    logic             rsp_valid;
    logic [DBITS-1:0] rsp_rdata;
    logic [3:0]       KEY = 4'hF;
    logic [9:0]       SW = '0;
    logic [6:0]       HEX0, HEX1, HEX2, HEX3;
    logic [9:0]       LEDR;
    logic [7:0]       LEDG;

    always #5 clk = ~clk;

    io_responder #(.DBITS(DBITS), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_hit(req_hit), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .KEY(KEY), .SW(SW),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
        .LEDR(LEDR), .LEDG(LEDG)
    );

    int checks   = 0;
    int failures = 0;

    // Active-low g..a digit glyphs.
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference state: register contents, key/switch delay lines, status bits.
    logic [15:0] m_hex = '0;
    logic [9:0]  m_ledr = '0, m_ledg10 = '0;
    logic [7:0]  m_ledg = '0;
    logic [3:0]  m_k0 = '0, m_k1 = '0, m_deb = '0;
    logic [9:0]  m_s0 = '0, m_s1 = '0;
    int          m_run [4] = '{0, 0, 0, 0};
    logic        m_ready = 1'b0, m_ovr = 1'b0, m_rv = 1'b0;
    logic [DBITS-1:0] exp_q [$];

    function automatic logic exp_hit(input logic [DBITS-1:0] a);
        return a[31:12] == 20'hF0000;
    endfunction

    task automatic chk(input string tag, input logic [DBITS-1:0] obs, input logic [DBITS-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_step();
        logic       acc, rd, chg, kd_rd;
        logic [9:0] w;
        logic [DBITS-1:0] rv;
        logic [3:0] pressed;
        if (reset) begin
            m_hex = '0; m_ledr = '0; m_ledg = '0;
            m_k0 = '0; m_k1 = '0; m_deb = '0; m_s0 = '0; m_s1 = '0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_ready = 1'b0; m_ovr = 1'b0; m_rv = 1'b0;
            exp_q.delete();
            return;
        end
        acc = req_valid && exp_hit(req_addr);
        rd  = acc && !req_we;
        w   = req_addr[11:2];
        rv  = '0;
        case (w)
            10'h000: rv = {16'h0, m_hex};
            10'h001: rv = {22'h0, m_ledr};
            10'h002: rv = {24'h0, m_ledg};
            10'h004: rv = {28'h0, m_deb};
            10'h005: rv = {22'h0, m_s1};
            10'h044: rv = {29'h0, m_ovr, 1'b0, m_ready};
            default: rv = '0;
        endcase
        // A key settles once it has disagreed for DC consecutive cycles.
        pressed = ~m_k1;
        chg = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (pressed[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == DC) begin
                    m_deb[i] = pressed[i];
                    m_run[i] = 0;
                    chg = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        kd_rd = rd && (w == 10'h004);
        if (chg && m_ready && !kd_rd) m_ovr = 1'b1;
        else if (acc && req_we && w == 10'h044 && !req_wdata[2]) m_ovr = 1'b0;
        if (chg) m_ready = 1'b1;
        else if (kd_rd) m_ready = 1'b0;
        if (acc && req_we) begin
            if (w == 10'h000) m_hex = req_wdata[15:0];
            if (w == 10'h001) m_ledr = req_wdata[9:0];
            if (w == 10'h002) m_ledg = req_wdata[7:0];
        end
        m_k1 = m_k0; m_k0 = KEY;
        m_s1 = m_s0; m_s0 = SW;
        m_rv = rd;
        if (rd) exp_q.push_back(rv);
    endtask

    task automatic step();
        logic [DBITS-1:0] e;
        chk("req_hit", {31'h0, req_hit}, {31'h0, exp_hit(req_addr)});
        @(posedge clk);
        model_step();
        #1;
        e = '0;
        if (m_rv && exp_q.size() > 0) e = exp_q.pop_front();
        chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, m_rv});
        chk("rsp_rdata", rsp_rdata, e);
        chk("LEDR", {22'h0, LEDR}, {22'h0, m_ledr});
        chk("LEDG", {24'h0, LEDG}, {24'h0, m_ledg});
        chk("HEX0", {25'h0, HEX0}, {25'h0, seg_tab[m_hex[3:0]]});
        chk("HEX1", {25'h0, HEX1}, {25'h0, seg_tab[m_hex[7:4]]});
        chk("HEX2", {25'h0, HEX2}, {25'h0, seg_tab[m_hex[11:8]]});
        chk("HEX3", {25'h0, HEX3}, {25'h0, seg_tab[m_hex[15:12]]});
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [DBITS-1:0] a, input logic [DBITS-1:0] d);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        step();
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    task automatic rd(input logic [DBITS-1:0] a);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = $urandom;
        step();
        req_valid = 1'b0;
    endtask

    logic [DBITS-1:0] addr_tab [10] = '{32'hF0000000, 32'hF0000004, 32'hF0000008, 32'hF0000010,
                                        32'hF0000014, 32'hF0000110, 32'hF0000020, 32'hF000000C,
                                        32'h00001000, 32'hF0001000};

    initial begin
        int hold;
        logic [DBITS-1:0] ctrl_at6;

        // Reset with a read pending: no response may emerge.
        reset = 1'b1; KEY = 4'hF; SW = '0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'hF0000000;
        idle(0);
        step(); step(); step();
        chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset_hex0", {25'h0, HEX0}, 32'h40);
        req_valid = 1'b0; reset = 1'b0;
        idle(4);

        // HEX register and segment decode.
        wr(32'hF0000000, 32'h0000A3F8);
        chk("hex0_8", {25'h0, HEX0}, 32'h00);
        chk("hex1_F", {25'h0, HEX1}, 32'h0E);
        chk("hex2_3", {25'h0, HEX2}, 32'h30);
        chk("hex3_A", {25'h0, HEX3}, 32'h08);
        rd(32'hF0000000);
        chk("hex_read", rsp_rdata, 32'h0000A3F8);

        // LEDR masking and read-only KEYDATA.
        wr(32'hF0000004, 32'hFFFFFFFF);
        rd(32'hF0000005);
        chk("ledr_read", rsp_rdata, 32'h000003FF);
        chk("ledr_pins", {22'h0, LEDR}, 32'h3FF);
        wr(32'hF0000010, 32'hF);
        rd(32'hF0000010);
        chk("keydata_ro", rsp_rdata, 32'h0);

        // KEY[0] press settles 6 edges later.
        KEY = 4'b1110;
        for (int i = 0; i < 6; i++) rd(32'hF0000110);
        ctrl_at6 = rsp_rdata;
        chk("ready_not_before_6", ctrl_at6, 32'h0);
        rd(32'hF0000110);
        chk("ready_at_6", rsp_rdata, 32'h1);
        rd(32'hF0000010);
        chk("keydata_at_6", rsp_rdata, 32'h1);
        rd(32'hF0000110);
        chk("ready_cleared", rsp_rdata, 32'h0);

        // Two-cycle release glitch is filtered.
        KEY = 4'b1111; idle(2);
        KEY = 4'b1110; idle(8);
        rd(32'hF0000010);
        chk("glitch_keydata", rsp_rdata, 32'h1);
        rd(32'hF0000110);
        chk("glitch_ready", rsp_rdata, 32'h0);

        // Overrun set, cleared by write-0, ready cleared by KEYDATA read.
        KEY = 4'b1100; idle(8);
        KEY = 4'b1000; idle(8);
        rd(32'hF0000110);
        chk("overrun_set", rsp_rdata, 32'h5);
        wr(32'hF0000110, 32'h0);
        rd(32'hF0000110);
        chk("overrun_clr", rsp_rdata, 32'h1);
        rd(32'hF0000010);
        chk("keydata_3keys", rsp_rdata, 32'h7);
        rd(32'hF0000110);
        chk("ctrl_idle", rsp_rdata, 32'h0);

        // KEYDATA read coinciding with a change while ready=1.
        KEY = 4'b0000; idle(8);
        KEY = 4'b1000; idle(5);
        rd(32'hF0000010);
        chk("coincide_keydata", rsp_rdata, 32'hF);
        rd(32'hF0000110);
        chk("coincide_ctrl", rsp_rdata, 32'h1);

        // Unmapped in-range read and out-of-range request.
        rd(32'hF0000020);
        chk("unmapped_valid", {31'h0, rsp_valid}, 32'h1);
        chk("unmapped_data", rsp_rdata, 32'h0);
        req_addr = 32'h00001000;
        chk("miss_hit", {31'h0, req_hit}, 32'h0);
        rd(32'h00001000);
        chk("miss_no_rsp", {31'h0, rsp_valid}, 32'h0);

        // Random traffic against the model.
        hold = 0;
        for (int c = 0; c < 600; c++) begin
            if (hold == 0) begin
                KEY  = 4'($urandom);
                hold = $urandom_range(1, 10);
            end
            hold--;
            SW        = 10'($urandom);
            req_valid = ($urandom_range(0, 3) != 0);
            req_we    = $urandom_range(0, 1) == 1;
            req_addr  = addr_tab[$urandom_range(0, 9)] | 32'($urandom_range(0, 3));
            req_wdata = $urandom;
            step();
        end
        req_valid = 1'b0;
        idle(3);

        // Reset mid-operation with a read in flight.
        wr(32'hF0000000, 32'h00001234);
        wr(32'hF0000004, 32'h00000155);
        wr(32'hF0000008, 32'h000000AA);
        reset = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'hF0000000;
        step();
        chk("rst_mid_rsp", {31'h0, rsp_valid}, 32'h0);
        chk("rst_mid_rdata", rsp_rdata, 32'h0);
        chk("rst_mid_ledr", {22'h0, LEDR}, 32'h0);
        chk("rst_mid_ledg", {24'h0, LEDG}, 32'h0);
        chk("rst_mid_hex3", {25'h0, HEX3}, 32'h40);
        req_valid = 1'b0; reset = 1'b0;
        idle(2);
        rd(32'hF0000110);
        chk("rst_mid_ctrl", rsp_rdata, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_responder.md
IO_RESPONDER -- requirements
Module: io_responder

Interface
- REQ-001 SHALL have parameter DBITS, default 32, data and address width.
- REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 100000, the number of stable cycles a synchronized KEY bit needs before its debounced value changes.
- REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
- REQ-005 SHALL have port req_valid  input  1  CPU presents an access this cycle.
- REQ-006 SHALL have port req_we  input  1  1 = write, 0 = read.
- REQ-007 SHALL have port req_addr  input  DBITS  byte address.
- REQ-008 SHALL have port req_wdata  input  DBITS  write data.
- REQ-009 SHALL have port req_hit  output  1  combinational; 1 when req_addr[31:12]==20'hF0000.
- REQ-010 SHALL have port rsp_valid  output  1  read data valid.
- REQ-011 SHALL have port rsp_rdata  output  DBITS  read data.
- REQ-012 SHALL have port KEY  input  4  raw pushbuttons, active-low, asynchronous.
- REQ-013 SHALL have port SW  input  10  raw switches, asynchronous.
- REQ-014 SHALL have ports HEX0, HEX1, HEX2, HEX3  output  7 each  active-low segments in g..a order.
- REQ-015 SHALL have port LEDR  output  10  red LEDs.
- REQ-016 SHALL have port LEDG  output  8  green LEDs.

Function
- REQ-017 SHALL accept an access in any cycle with req_valid=1 and req_hit=1; there are no wait states.
- REQ-018 SHALL use the following register map on word addresses, ignoring req_addr[1:0]:
  - F0000000 HEX, RW, 16 bits
  - F0000004 LEDR, RW, 10 bits
  - F0000008 LEDG, RW, 8 bits
  - F0000010 KEYDATA, RO, 4 bits
  - F0000014 SWDATA, RO, 10 bits
  - F0000110 KEYCTRL, RW: bit0 ready (RO), bit2 overrun (write-0-to-clear)
- REQ-019 SHALL, for an accepted write, update the target register at that clock edge from the low bits of req_wdata; writes to RO or unmapped addresses SHALL have no effect.
- REQ-020 SHALL, for an accepted read, drive rsp_valid=1 and rsp_rdata (zero-extended register value) in exactly the next cycle.
- REQ-021 SHALL drive rsp_valid=0 and rsp_rdata=0 in all other cycles.
- REQ-022 SHALL return 0 for reads of unmapped in-range addresses, with rsp_valid=1.
- REQ-023 SHALL decode each HEX nibble combinationally to active-low 7-segment: HEX0=bits[3:0] through HEX3=bits[15:12]; 0 -> 1000000, 1 -> 1111001, ..., 8 -> 0000000, A -> 0001000, F -> 0001110.
- REQ-024 SHALL drive LEDR and LEDG directly from their registers.
- REQ-025 SHALL pass SW through a 2-flop synchronizer; SWDATA is the synchronizer output.
- REQ-026 SHALL pass each KEY bit through a 2-flop synchronizer, then invert it (pressed=1).
- REQ-027 SHALL debounce each bit with its own counter: the counter resets to 0 whenever the synchronized value equals the debounced value, otherwise increments; when it reaches DEBOUNCE_CYCLES-1, the debounced bit takes the synchronized value and the counter clears.
- REQ-028 KEYDATA SHALL be the 4 debounced bits.
- REQ-029 SHALL set ready in the cycle any debounced bit changes.
- REQ-030 SHALL clear ready on an accepted read of KEYDATA.
- REQ-031 SHALL keep ready=1 when a change and a KEYDATA read coincide (set wins).
- REQ-032 SHALL set overrun when a debounced change occurs while ready=1 and no KEYDATA read is accepted that cycle.
- REQ-033 SHALL keep overrun set until a KEYCTRL write with wdata[2]=0; if a clear write and a new overrun coincide, overrun stays 1.
- REQ-034 SHALL use total latency from raw KEY edge to debounced change of 2 synchronizer cycles + DEBOUNCE_CYCLES.

Reset
- REQ-035 SHALL, while reset=1 at a rising edge, clear HEX, LEDR, LEDG, the synchronizers, the debounced KEY bits, the debounce counters, ready, overrun, rsp_valid and rsp_rdata to 0.
- REQ-036 SHALL, after reset, show HEX0..HEX3 = 1000000 each.
- REQ-037 SHALL discard a read accepted in the same cycle as reset: rsp_valid=0 next cycle.

Verification (DEBOUNCE_CYCLES=4)
- REQ-038 Write F0000000 <- 0x0000A3F8, then read it -> HEX0=0000000, HEX1=0001110, HEX2=0110000, HEX3=0001000; next-cycle rsp_rdata=0x0000A3F8.
- REQ-039 Write LEDR <- 0xFFFFFFFF, then read -> LEDR=10'h3FF, rsp_rdata=0x000003FF; write F0000010 <- 0xF, then read -> still 0.
- REQ-040 Drive KEY=1110 stable -> KEYDATA=0x1 and ready=1 exactly 6 cycles later; a 2-cycle glitch on KEY[0] -> no change.
- REQ-041 With ready=1, trigger a second key change without reading -> KEYCTRL reads 0x5; write KEYCTRL <- 0 -> reads 0x1; read KEYDATA -> KEYCTRL reads 0x0.
- REQ-042 Read KEYDATA in the same cycle as a debounced change -> ready=1, overrun=0; read F0000020 -> rsp_valid=1, rdata=0; request to 0x00001000 -> req_hit=0, no response.
- REQ-043 Assert reset mid-operation after HEX/LED writes and a pending read -> all outputs at reset values, no rsp_valid.
